// File: rtl/score_flash_sequencer.sv
// Score persistence sequencer: saves/restores N_BYTES of scores to NOR
// flash one byte at a time, with read-back verify after every save.
// Ports: CLK_50MHZ/RST clock and sync active-high reset;
// save_req/restore_req one-cycle requests; score_in/score_out bytes;
// busy/done/err status; fb_* single-byte Flash handshake.
module score_flash_sequencer #(
  parameter int         N_BYTES      = 4,
  parameter logic [7:0] BASE_ADDR    = 8'd0,
  parameter bit         AUTO_RESTORE = 1'b1,
  parameter int         TIMEOUT      = 65535
) (
  input  logic                 CLK_50MHZ,
  input  logic                 RST,
  input  logic                 save_req,
  input  logic                 restore_req,
  input  logic [8*N_BYTES-1:0] score_in,
  output logic [8*N_BYTES-1:0] score_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           fb_addr,
  output logic [7:0]           fb_data,
  input  logic [7:0]           fb_q,
  output logic                 fb_rw,
  output logic                 fb_start,
  input  logic                 fb_done
);

  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_BYTES - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_WAIT_REL,
    S_NEXT,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    PH_WRITE,
    PH_VERIFY,
    PH_RESTORE
  } phase_t;

  typedef logic [N_BYTES-1:0][7:0] bytes_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   cnt_q, cnt_d;
  bytes_t        shadow_q, shadow_d;
  bytes_t        rbuf_q, rbuf_d;
  bytes_t        score_q, score_d;
  logic          auto_q, auto_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          rw_q, rw_d;
  logic          start_q, start_d;
  logic          go_issue;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    rbuf_d   = rbuf_q;
    score_d  = score_q;
    auto_d   = auto_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rw_d     = rw_q;
    start_d  = 1'b0;
    go_issue = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // restore (manual or post-reset) beats a same-cycle save
        if (restore_req || auto_q) begin
          phase_d  = PH_RESTORE;
          idx_d    = '0;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          auto_d   = 1'b0;
          go_issue = 1'b1;
          state_d  = S_ISSUE;
        end else if (save_req) begin
          shadow_d = score_in;
          phase_d  = PH_WRITE;
          idx_d    = '0;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          go_issue = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (fb_done) begin
          cnt_d   = '0;
          state_d = S_WAIT_REL;
          if (phase_q == PH_RESTORE) begin
            rbuf_d[idx_q] = fb_q;
          end else if (phase_q == PH_VERIFY &&
                       fb_q != shadow_q[idx_q]) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_REL: begin
        if (!fb_done) begin
          state_d = S_NEXT;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_NEXT: begin
        if (idx_q != LAST) begin
          idx_d    = idx_q + 1'b1;
          go_issue = 1'b1;
          state_d  = S_ISSUE;
        end else if (phase_q == PH_WRITE) begin
          phase_d  = PH_VERIFY;
          idx_d    = '0;
          go_issue = 1'b1;
          state_d  = S_ISSUE;
        end else begin
          // only a clean, complete restore reaches this commit
          if (phase_q == PH_RESTORE) begin
            score_d = rbuf_q;
          end
          done_d  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // bus lines are loaded only here, so they hold until the next issue
    if (go_issue) begin
      start_d = 1'b1;
      addr_d  = BASE_ADDR + 8'(idx_d);
      rw_d    = (phase_d != PH_WRITE);
      data_d  = (phase_d == PH_WRITE) ? shadow_d[idx_d] : 8'h00;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_RESTORE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      rbuf_q   <= '0;
      score_q  <= '0;
      auto_q   <= AUTO_RESTORE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      rw_q     <= 1'b1;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      rbuf_q   <= rbuf_d;
      score_q  <= score_d;
      auto_q   <= auto_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rw_q     <= rw_d;
      start_q  <= start_d;
    end
  end

  assign score_out = score_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign fb_addr   = addr_q;
  assign fb_data   = data_q;
  assign fb_rw     = rw_q;
  assign fb_start  = start_q;

endmodule

// File: tb/tb_score_flash_sequencer.sv
// Bench for score_flash_sequencer: flash model plus transaction-level
// reference of the save/verify/restore rules, checked every cycle.
module tb_score_flash_sequencer;

  localparam int NB = 4;
  localparam int TO = 100;

  typedef struct packed {
    logic [7:0] addr;
    logic       rw;
    logic [7:0] data;
  } txn_t;

  logic        clk;
  logic        RST;
  logic        save_req;
  logic        restore_req;
  logic [31:0] score_in;
  logic [31:0] score_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  fb_addr;
  logic [7:0]  fb_data;
  logic [7:0]  fb_q;
  logic        fb_rw;
  logic        fb_start;
  logic        fb_done;

  score_flash_sequencer #(
    .N_BYTES(NB),
    .BASE_ADDR(8'd0),
    .AUTO_RESTORE(1'b1),
    .TIMEOUT(TO)
  ) dut (
    .CLK_50MHZ(clk),
    .RST(RST),
    .save_req(save_req),
    .restore_req(restore_req),
    .score_in(score_in),
    .score_out(score_out),
    .busy(busy),
    .done(done),
    .err(err),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .fb_q(fb_q),
    .fb_rw(fb_rw),
    .fb_start(fb_start),
    .fb_done(fb_done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [256];
  int          corrupt_addr = -1;
  bit          hang = 1'b0;

  txn_t        expq[$];
  bit          pending = 1'b0;
  bit          exp_err = 1'b0;
  bit          exp_restore = 1'b0;
  logic [31:0] exp_val = '0;
  logic [31:0] model_score = '0;

  int          cyc = 0;
  int          start_cnt = 0;
  int          last_start_cyc = 0;
  int          done_cyc = 0;
  bit          prev_start = 1'b0;
  bit          prev_done = 1'b0;
  bit          txn_open = 1'b0;
  txn_t        cur;
  bit          rst_at_edge = 1'b0;

  always @(posedge clk) rst_at_edge <= RST;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic push_txn(input int a, input bit rw,
                          input logic [7:0] d);
    txn_t t;
    t.addr = 8'(a);
    t.rw = rw;
    t.data = d;
    expq.push_back(t);
  endtask

  // expected transaction list and outcome of one sequence
  task automatic predict(input bit is_restore,
                         input logic [31:0] d);
    logic [7:0] v;
    txn_t f;
    expq.delete();
    exp_err = 1'b0;
    exp_restore = is_restore;
    exp_val = '0;
    pending = 1'b1;
    if (is_restore) begin
      for (int i = 0; i < NB; i++) begin
        push_txn(i, 1'b1, 8'h00);
        v = (corrupt_addr == i) ? 8'h00 : mem[i];
        exp_val[8*i +: 8] = v;
      end
    end else begin
      for (int i = 0; i < NB; i++)
        push_txn(i, 1'b0, d[8*i +: 8]);
      for (int i = 0; i < NB; i++) begin
        push_txn(i, 1'b1, 8'h00);
        v = (corrupt_addr == i) ? 8'h00 : d[8*i +: 8];
        if (v != d[8*i +: 8]) begin
          exp_err = 1'b1;
          break;
        end
      end
    end
    if (hang) begin
      f = expq[0];
      expq.delete();
      expq.push_back(f);
      exp_err = 1'b1;
    end
  endtask

  // flash byte-access model
  initial begin
    logic [7:0] a;
    bit rw;
    bit abort;
    int lat;
    int hold;
    fb_done = 1'b0;
    fb_q = 8'h00;
    forever begin
      @(negedge clk);
      if (!RST && fb_start) begin
        a = fb_addr;
        rw = fb_rw;
        if (!rw) mem[a] = fb_data;
        if (!hang) begin
          lat = $urandom_range(1, 6);
          hold = $urandom_range(1, 3);
          abort = 1'b0;
          for (int k = 0; k < lat && !abort; k++) begin
            @(posedge clk); #2;
            if (RST) abort = 1'b1;
          end
          if (!abort) begin
            fb_done = 1'b1;
            fb_q = (rw && corrupt_addr == int'(a)) ? 8'h00 : mem[a];
            for (int k = 0; k < hold && !abort; k++) begin
              @(posedge clk); #2;
              if (RST) abort = 1'b1;
            end
          end
          fb_done = 1'b0;
          fb_q = 8'h00;
        end
      end
    end
  end

  // per-cycle compare against the reference
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_at_edge) begin
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(done == 1'b0, "rst_done", done, 0);
        chk(err == 1'b0, "rst_err", err, 0);
        chk(fb_start == 1'b0, "rst_fb_start", fb_start, 0);
        chk(fb_rw == 1'b1, "rst_fb_rw", fb_rw, 1);
        chk(fb_addr == 8'h00, "rst_fb_addr", fb_addr, 0);
        chk(fb_data == 8'h00, "rst_fb_data", fb_data, 0);
        chk(score_out == 32'h0, "rst_score", score_out, 0);
      end
      if (RST) begin
        model_score = '0;
        txn_open = 1'b0;
        prev_start = 1'b0;
        prev_done = 1'b0;
        start_cnt = 0;
        predict(1'b1, 32'h0);
      end else begin
        if (fb_start) begin
          chk(!prev_start, "start_width", 2, 1);
          chk(fb_done == 1'b0, "start_while_done", fb_done, 0);
          chk(expq.size() != 0, "unexpected_start", fb_addr, 0);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk(fb_addr == e.addr, "txn_addr", fb_addr, e.addr);
            chk(fb_rw == e.rw, "txn_rw", fb_rw, e.rw);
            chk(fb_data == e.data, "txn_data", fb_data, e.data);
          end
          start_cnt++;
          last_start_cyc = cyc;
          txn_open = 1'b1;
          cur.addr = fb_addr;
          cur.rw = fb_rw;
          cur.data = fb_data;
        end else if (txn_open) begin
          chk(fb_addr == cur.addr && fb_rw == cur.rw &&
              fb_data == cur.data, "bus_stable",
              {fb_addr, 7'd0, fb_rw, fb_data},
              {cur.addr, 7'd0, cur.rw, cur.data});
        end
        if (done) begin
          chk(!prev_done, "done_width", 2, 1);
          chk(pending, "done_expected", done, pending);
          chk(err == exp_err, "err_at_done", err, exp_err);
          chk(expq.size() == 0, "txn_count", expq.size(), 0);
          chk(busy == 1'b1, "busy_in_done", busy, 1);
          if (pending && !exp_err && exp_restore)
            model_score = exp_val;
          pending = 1'b0;
          txn_open = 1'b0;
          done_cyc = cyc;
        end
        if (prev_done)
          chk(busy == 1'b0, "busy_after_done", busy, 0);
        chk(score_out == model_score, "score_out",
            score_out, model_score);
        prev_start = fb_start;
        prev_done = done;
      end
    end
  end

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 2000);
    chk(done == 1'b1, {nm, "_done_seen"}, done, 1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 2000);
    chk(busy == 1'b0, "idle_seen", busy, 0);
  endtask

  task automatic wait_starts(input int k);
    int n;
    n = 0;
    while (start_cnt < k && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk(start_cnt >= k, "starts_reached", start_cnt, k);
  endtask

  task automatic issue(input bit sv, input bit rs,
                       input logic [31:0] d);
    wait_idle();
    @(posedge clk); #1;
    start_cnt = 0;
    save_req = sv;
    restore_req = rs;
    score_in = d;
    predict(rs, d);
    @(posedge clk); #1;
    save_req = 1'b0;
    restore_req = 1'b0;
    score_in = $urandom();
  endtask

  task automatic pulse_save();
    @(posedge clk); #1;
    save_req = 1'b1;
    score_in = $urandom();
    @(posedge clk); #1;
    save_req = 1'b0;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] x;
    logic [31:0] d;
    int op;
    RST = 1'b1;
    save_req = 1'b0;
    restore_req = 1'b0;
    score_in = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    mem[3] = 8'h44;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;

    // auto restore after reset
    wait_done("t1");
    chk(score_out == 32'h44332211, "t1_score", score_out, 32'h44332211);
    chk(start_cnt == 4, "t1_reads", start_cnt, 4);
    chk(err == 1'b0, "t1_err", err, 0);

    // save with verify
    issue(1'b1, 1'b0, 32'h6D0DC9A5);
    wait_done("t2");
    chk(err == 1'b0, "t2_err", err, 0);
    chk(start_cnt == 8, "t2_txns", start_cnt, 8);
    chk({mem[3], mem[2], mem[1], mem[0]} == 32'h6D0DC9A5, "t2_flash",
        {mem[3], mem[2], mem[1], mem[0]}, 32'h6D0DC9A5);
    chk(score_out == 32'h44332211, "t2_score", score_out, 32'h44332211);

    // verify mismatch on byte 2
    corrupt_addr = 2;
    issue(1'b1, 1'b0, 32'h6D0DC9A5);
    wait_done("t3");
    chk(err == 1'b1, "t3_err", err, 1);
    chk(start_cnt == 7, "t3_txns", start_cnt, 7);
    corrupt_addr = -1;

    // timeout
    hang = 1'b1;
    issue(1'b0, 1'b1, 32'h0);
    wait_done("t4");
    chk(err == 1'b1, "t4_err", err, 1);
    chk(start_cnt == 1, "t4_starts", start_cnt, 1);
    chk(done_cyc - last_start_cyc == TO + 1, "t4_latency",
        done_cyc - last_start_cyc, TO + 1);
    hang = 1'b0;
    issue(1'b0, 1'b1, 32'h0);
    @(negedge clk);
    chk(busy == 1'b1 && err == 1'b0, "t4_err_clear",
        {busy, err}, 2'b10);
    wait_done("t4b");
    chk(score_out == 32'h6D0DC9A5, "t4_score", score_out, 32'h6D0DC9A5);

    // simultaneous requests, save during busy
    issue(1'b1, 1'b1, 32'hDEADBEEF);
    wait_starts(2);
    pulse_save();
    wait_done("t5");
    chk(start_cnt == 4, "t5_reads", start_cnt, 4);
    chk(err == 1'b0, "t5_err", err, 0);
    chk(score_out == 32'h6D0DC9A5, "t5_score", score_out, 32'h6D0DC9A5);

    // reset during second write
    x = $urandom();
    issue(1'b1, 1'b0, x);
    wait_starts(2);
    #1 RST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(busy == 1'b0 && fb_start == 1'b0, "t6_abort",
        {busy, fb_start}, 0);
    chk(score_out == 32'h0, "t6_score0", score_out, 0);
    @(posedge clk); #1;
    RST = 1'b0;
    wait_done("t6");
    chk(score_out == {8'h6D, 8'h0D, x[15:0]}, "t6_restore",
        score_out, {8'h6D, 8'h0D, x[15:0]});

    // randomized traffic
    for (int r = 0; r < 12; r++) begin
      op = $urandom_range(0, 2);
      d = $urandom();
      issue(op != 1, op != 0, d);
      if ($urandom_range(0, 1) == 1) begin
        wait_starts(1);
        pulse_save();
      end
      wait_done("rand");
    end

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
